// File: rtl/ula_seq_pkg.sv
// Shared types and constants for the ULA sequencer: FSM states, opcodes and
// instruction field positions.
package ula_seq_pkg;

  localparam int INSTR_W     = 16;
  localparam int OP_LO       = 13;
  localparam int IMM_SEL_BIT = 12;
  localparam int RD_LO       = 9;
  localparam int RS_LO       = 6;
  localparam int RT_LO       = 3;
  localparam int IMM_LO      = 0;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC,
    WB,
    HOLD
  } state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: is_legal_op = 1'b1;
      default:                               is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ula_seq_ctrl_decode.sv
// Combinational instruction decoder: splits the fields, zero-extends the
// immediate and flags illegal opcodes.
module ula_seq_ctrl_decode
  import ula_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int IMM_W  = 6
) (
  input  logic [INSTR_W-1:0] i_instr,
  output logic [2:0]         o_op,
  output logic               o_imm_sel,
  output logic [ADDR_W-1:0]  o_rd,
  output logic [ADDR_W-1:0]  o_rs,
  output logic [ADDR_W-1:0]  o_rt,
  output logic [DATA_W-1:0]  o_imm_ext,
  output logic               o_legal
);

  logic [IMM_W-1:0] w_imm;

  assign o_op      = i_instr[OP_LO +: 3];
  assign o_imm_sel = i_instr[IMM_SEL_BIT];
  assign o_rd      = i_instr[RD_LO +: ADDR_W];
  assign o_rs      = i_instr[RS_LO +: ADDR_W];
  assign o_rt      = i_instr[RT_LO +: ADDR_W];
  // The immediate overlaps rt; which one matters is chosen by imm_sel downstream.
  assign w_imm     = i_instr[IMM_LO +: IMM_W];
  assign o_imm_ext = {{(DATA_W - IMM_W){1'b0}}, w_imm};
  assign o_legal   = is_legal_op(o_op);

endmodule

// File: rtl/ula_seq_ctrl.sv
// Multicycle sequencer driving the register file and ULA: IDLE -> DECODE ->
// EXEC -> WB. Optional ULA_SEQ_STEP_EN adds a step input and a HOLD state before WB.
module ula_seq_ctrl
  import ula_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int IMM_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
`ifdef ULA_SEQ_STEP_EN
  input  logic               step,
`endif
  input  logic               instr_valid,
  input  logic [15:0]        instr_in,
  output logic               instr_ready,
  output logic [ADDR_W-1:0]  ra1,
  output logic [ADDR_W-1:0]  ra2,
  output logic [ADDR_W-1:0]  wa3,
  output logic               we3,
  output logic [DATA_W-1:0]  wd3,
  output logic               ula_src,
  output logic [DATA_W-1:0]  imm_out,
  output logic [2:0]         ula_control,
  input  logic [DATA_W-1:0]  ula_result_in,
  input  logic               flag_z_in,
  output logic               done,
  output logic [DATA_W-1:0]  result_out,
  output logic               zero_out,
  output logic               illegal,
  output logic               busy
);

  state_e              r_state;
  state_e              w_next_state;
  logic [INSTR_W-1:0]  r_instr;
  logic [DATA_W-1:0]   r_result;
  logic                r_zero;
  logic [ADDR_W-1:0]   r_wa3;

  logic [2:0]          w_op;
  logic                w_imm_sel;
  logic [ADDR_W-1:0]   w_rd;
  logic [ADDR_W-1:0]   w_rs;
  logic [ADDR_W-1:0]   w_rt;
  logic [DATA_W-1:0]   w_imm_ext;
  logic                w_legal;

  // Decoding the held instruction register keeps the datapath controls stable
  // from DECODE until the next accepted instruction.
  ula_seq_ctrl_decode #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .IMM_W  (IMM_W)
  ) u_decode (
    .i_instr   (r_instr),
    .o_op      (w_op),
    .o_imm_sel (w_imm_sel),
    .o_rd      (w_rd),
    .o_rs      (w_rs),
    .o_rt      (w_rt),
    .o_imm_ext (w_imm_ext),
    .o_legal   (w_legal)
  );

  always_comb begin
    // NOTE: default assigned first so every path drives w_next_state and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      IDLE:   if (instr_valid) w_next_state = DECODE;
      DECODE: w_next_state = w_legal ? EXEC : IDLE;
`ifdef ULA_SEQ_STEP_EN
      EXEC:   w_next_state = HOLD;
      HOLD:   if (step) w_next_state = WB;
`else
      EXEC:   w_next_state = WB;
      HOLD:   w_next_state = IDLE;
`endif
      WB:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_instr  <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_wa3    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next_state;
      if (r_state == IDLE && instr_valid) r_instr <= instr_in;
      if (r_state == EXEC) begin
        r_result <= ula_result_in;
        r_zero   <= flag_z_in;
      end
      if (w_next_state == WB) r_wa3 <= w_rd;
    end
  end

  assign instr_ready = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign illegal     = (r_state == DECODE) && !w_legal;
  assign we3         = (r_state == WB);
  assign done        = (r_state == WB);
  assign wa3         = r_wa3;
  assign wd3         = r_result;
  assign result_out  = r_result;
  assign zero_out    = r_zero;
  assign ra1         = w_rs;
  assign ra2         = w_rt;
  assign ula_src     = w_imm_sel;
  assign imm_out     = w_imm_ext;
  assign ula_control = w_op;

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Self-checking bench for ula_seq_ctrl: per-scenario tasks plus a write-back
// scoreboard fed at stimulus time and drained by a monitor on we3.
module tb_ula_seq_ctrl;

`ifdef ULA_SEQ_STEP_EN
  localparam int HOLD_CYC = 1;
`else
  localparam int HOLD_CYC = 0;
`endif
  localparam int PERIOD = 4 + HOLD_CYC;

  typedef struct {
    logic [2:0] wa3;
    logic [7:0] wd3;
    logic       z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_in = '0;
  logic        instr_ready;
  logic [2:0]  ra1, ra2, wa3;
  logic        we3;
  logic [7:0]  wd3;
  logic        ula_src;
  logic [7:0]  imm_out;
  logic [2:0]  ula_control;
  logic [7:0]  ula_result_in = '0;
  logic        flag_z_in = 1'b0;
  logic        done;
  logic [7:0]  result_out;
  logic        zero_out;
  logic        illegal;
  logic        busy;
`ifdef ULA_SEQ_STEP_EN
  logic        step = 1'b1;
`endif

  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   done_count = 0;
  int   done_cyc_q[$];
  exp_t exp_q[$];
  exp_t mon_e;

  ula_seq_ctrl dut (
    .clk           (clk),
    .rst           (rst),
`ifdef ULA_SEQ_STEP_EN
    .step          (step),
`endif
    .instr_valid   (instr_valid),
    .instr_in      (instr_in),
    .instr_ready   (instr_ready),
    .ra1           (ra1),
    .ra2           (ra2),
    .wa3           (wa3),
    .we3           (we3),
    .wd3           (wd3),
    .ula_src       (ula_src),
    .imm_out       (imm_out),
    .ula_control   (ula_control),
    .ula_result_in (ula_result_in),
    .flag_z_in     (flag_z_in),
    .done          (done),
    .result_out    (result_out),
    .zero_out      (zero_out),
    .illegal       (illegal),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (!rst && done) begin
      done_count++;
      done_cyc_q.push_back(cycle);
    end
  end

  always @(negedge clk) begin
    if (!rst && we3) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got wa3=%0d wd3=%h, no write expected", wa3, wd3);
      end else begin
        mon_e = exp_q.pop_front();
        if ({wa3, wd3, zero_out, done} !== {mon_e.wa3, mon_e.wd3, mon_e.z, 1'b1}) begin
          failures++;
          $display("FAIL writeback got wa3=%0d wd3=%h z=%b done=%b expected wa3=%0d wd3=%h z=%b done=1",
                   wa3, wd3, zero_out, done, mon_e.wa3, mon_e.wd3, mon_e.z);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offers one instruction and returns in the DECODE cycle (N+1).
  task automatic send(input logic [15:0] instr, input logic [7:0] res, input logic z);
    int n = 0;
    instr_valid   = 1'b1;
    instr_in      = instr;
    ula_result_in = res;
    flag_z_in     = z;
    while (!instr_ready && n < 20) begin
      cyc();
      n++;
    end
    if (!instr_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout instr_ready=%b required 1", instr_ready);
    end
    cyc();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cyc();
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b required 1", instr_ready);
    end
    checks++;
    if ({ra1, ra2, wa3, we3, wd3, ula_src, imm_out, ula_control, done, result_out,
         zero_out, illegal, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got %h required 0",
               {ra1, ra2, wa3, we3, wd3, ula_src, imm_out, ula_control, done, result_out,
                zero_out, illegal, busy});
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_add();
    exp_q.push_back('{wa3: 3'd5, wd3: 8'h0C, z: 1'b0});
    send(16'h4A54, 8'h0C, 1'b0);
    checks++;
    if ({ra1, ra2, ula_src, ula_control, busy, instr_ready} !==
        {3'd1, 3'd2, 1'b0, 3'b010, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL decode_add got ra1=%0d ra2=%0d src=%b ctl=%b busy=%b rdy=%b required 1 2 0 010 1 0",
               ra1, ra2, ula_src, ula_control, busy, instr_ready);
    end
    cyc();
    checks++;
    if ({we3, done} !== 2'b00) begin
      failures++;
      $display("FAIL exec_no_write got we3=%b done=%b required 0 0", we3, done);
    end
    repeat (HOLD_CYC) cyc();
    cyc();
    checks++;
    if ({done, we3, wa3, wd3} !== {1'b1, 1'b1, 3'd5, 8'h0C}) begin
      failures++;
      $display("FAIL wb_add got done=%b we3=%b wa3=%0d wd3=%h required 1 1 5 0c",
               done, we3, wa3, wd3);
    end
    cyc();
    checks++;
    if ({instr_ready, done, we3, busy} !== 4'b1000) begin
      failures++;
      $display("FAIL ready_after_add got rdy=%b done=%b we3=%b busy=%b required 1 0 0 0",
               instr_ready, done, we3, busy);
    end
    checks++;
    if ({result_out, wa3} !== {8'h0C, 3'd5}) begin
      failures++;
      $display("FAIL hold_after_add got result=%h wa3=%0d required 0c 5", result_out, wa3);
    end
  endtask

  task automatic test_imm();
    exp_q.push_back('{wa3: 3'd0, wd3: 8'h00, z: 1'b1});
    send(16'hD007, 8'h00, 1'b1);
    checks++;
    if ({ula_src, imm_out, ula_control, ra1} !== {1'b1, 8'h07, 3'b110, 3'd0}) begin
      failures++;
      $display("FAIL decode_imm got src=%b imm=%h ctl=%b ra1=%0d required 1 07 110 0",
               ula_src, imm_out, ula_control, ra1);
    end
    repeat (2 + HOLD_CYC) cyc();
    checks++;
    if ({we3, wa3, wd3, zero_out} !== {1'b1, 3'd0, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL wb_imm got we3=%b wa3=%0d wd3=%h z=%b required 1 0 00 1",
               we3, wa3, wd3, zero_out);
    end
    cyc();
  endtask

  task automatic test_illegal();
    int d0 = done_count;
    send(16'h6000, 8'hFF, 1'b0);
    checks++;
    if ({illegal, we3, done} !== 3'b100) begin
      failures++;
      $display("FAIL illegal_pulse got illegal=%b we3=%b done=%b required 1 0 0", illegal, we3, done);
    end
    cyc();
    checks++;
    if ({instr_ready, busy, illegal} !== 3'b100) begin
      failures++;
      $display("FAIL illegal_idle got rdy=%b busy=%b illegal=%b required 1 0 0",
               instr_ready, busy, illegal);
    end
    repeat (4) cyc();
    checks++;
    if (done_count != d0 || result_out !== 8'h00) begin
      failures++;
      $display("FAIL illegal_no_effect got dones=%0d result=%h required 0 00", done_count - d0, result_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog [3] = '{16'h2728, 16'h1EAA, 16'hE3B8};
    logic [7:0]  res  [3] = '{8'h35, 8'h02, 8'h01};
    logic [2:0]  rd   [3] = '{3'd3, 3'd7, 3'd1};
    int d0 = done_count;
    int n;
    done_cyc_q.delete();
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!instr_ready && n < 20) begin
        cyc();
        n++;
      end
      instr_in      = prog[k];
      ula_result_in = res[k];
      flag_z_in     = 1'b0;
      exp_q.push_back('{wa3: rd[k], wd3: res[k], z: 1'b0});
      cyc();
      instr_in = 16'($urandom);
    end
    instr_valid = 1'b0;
    n = 0;
    while (done_count < d0 + 3 && n < 40) begin
      cyc();
      n++;
    end
    repeat (2) cyc();
    checks++;
    if (done_count - d0 != 3) begin
      failures++;
      $display("FAIL b2b_count got %0d done pulses required 3", done_count - d0);
    end
    checks++;
    if (done_cyc_q.size() != 3 || done_cyc_q[1] - done_cyc_q[0] != PERIOD ||
        done_cyc_q[2] - done_cyc_q[1] != PERIOD) begin
      failures++;
      $display("FAIL b2b_spacing got %p required spacing %0d", done_cyc_q, PERIOD);
    end
  endtask

  task automatic test_reset_mid();
    int d0 = done_count;
    send(16'h4A54, 8'hAA, 1'b1);
    cyc();
    rst = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_ready got %b required 1", instr_ready);
    end
    checks++;
    if ({ra1, ra2, wa3, we3, wd3, ula_src, imm_out, ula_control, done, result_out,
         zero_out, illegal, busy} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs got %h required 0",
               {ra1, ra2, wa3, we3, wd3, ula_src, imm_out, ula_control, done, result_out,
                zero_out, illegal, busy});
    end
    repeat (2) cyc();
    rst = 1'b0;
    repeat (6) cyc();
    checks++;
    if (done_count != d0 || result_out !== 8'h00) begin
      failures++;
      $display("FAIL midrst_aborted got dones=%0d result=%h required 0 00", done_count - d0, result_out);
    end
  endtask

`ifdef ULA_SEQ_STEP_EN
  task automatic test_step();
    int bad = 0;
    step = 1'b0;
    exp_q.push_back('{wa3: 3'd5, wd3: 8'h5A, z: 1'b0});
    send(16'h4A54, 8'h5A, 1'b0);
    repeat (2) cyc();
    for (int i = 0; i < 10; i++) begin
      if ({we3, done, busy} !== 3'b001) bad++;
      cyc();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL step_hold got %0d bad cycles required 0", bad);
    end
    step = 1'b1;
    cyc();
    checks++;
    if ({we3, done, wa3} !== {1'b1, 1'b1, 3'd5}) begin
      failures++;
      $display("FAIL step_release got we3=%b done=%b wa3=%0d required 1 1 5", we3, done, wa3);
    end
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_illegal();
    test_back_to_back();
`ifdef ULA_SEQ_STEP_EN
    test_step();
`endif
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending writes required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
